// File: rtl/vscale_htif_pcr_responder_pkg.sv
// Shared constants for the HTIF PCR responder: data width, host CSR addresses,
// and the response buffer state encoding.
package vscale_htif_pcr_responder_pkg;

  localparam int unsigned HTIF_PCR_WIDTH = 64;
  localparam int unsigned CSR_ADDR_WIDTH = 12;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST   = 12'h780;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_FROM_HOST = 12'h781;

  typedef enum logic {
    HTIF_RESP_EMPTY = 1'b0,
    HTIF_RESP_FULL  = 1'b1
  } htif_resp_state_e;

endpackage

// File: rtl/vscale_htif_resp_buf.sv
// Single-entry valid/ready response buffer; a drain and a load may happen in
// the same cycle so the host can issue back-to-back requests.
module vscale_htif_resp_buf
  import vscale_htif_pcr_responder_pkg::*;
#(
  parameter int unsigned WIDTH = HTIF_PCR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             resp_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             req_ready
);

  htif_resp_state_e state;

  // load is only raised when req_ready is high, so FULL & load implies a drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HTIF_RESP_EMPTY;
      resp_data <= '0;
    end else begin
      case (state)
        HTIF_RESP_EMPTY: begin
          if (load) begin
            state     <= HTIF_RESP_FULL;
            resp_data <= load_data;
          end
        end
        HTIF_RESP_FULL: begin
          if (load) begin
            resp_data <= load_data;
          end else if (resp_ready) begin
            state <= HTIF_RESP_EMPTY;
          end
        end
        default: state <= HTIF_RESP_EMPTY;
      endcase
    end
  end

  assign resp_valid = (state == HTIF_RESP_FULL);
  assign req_ready  = !reset && (!resp_valid || resp_ready);

endmodule

// File: rtl/vscale_htif_pcr_responder.sv
// Target-side HTIF PCR endpoint: owns to_host/from_host, decodes host requests
// and serves the core side port. Core writes take priority over host updates.
module vscale_htif_pcr_responder
  import vscale_htif_pcr_responder_pkg::*;
#(
  parameter int unsigned PCR_WIDTH  = HTIF_PCR_WIDTH,
  parameter int unsigned ADDR_WIDTH = CSR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  htif_pcr_req_valid,
  output logic                  htif_pcr_req_ready,
  input  logic                  htif_pcr_req_rw,
  input  logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
  input  logic [PCR_WIDTH-1:0]  htif_pcr_req_data,
  output logic                  htif_pcr_resp_valid,
  input  logic                  htif_pcr_resp_ready,
  output logic [PCR_WIDTH-1:0]  htif_pcr_resp_data,
  input  logic                  core_wen,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [PCR_WIDTH-1:0]  core_wdata,
  output logic [PCR_WIDTH-1:0]  core_rdata,
  output logic                  tohost_pending
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TO_HOST   = ADDR_WIDTH'(CSR_ADDR_TO_HOST);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FROM_HOST = ADDR_WIDTH'(CSR_ADDR_FROM_HOST);

  logic [PCR_WIDTH-1:0] to_host, from_host;
  logic [PCR_WIDTH-1:0] to_host_nxt, from_host_nxt;
  logic [PCR_WIDTH-1:0] resp_load_data;
  logic                 req_fire;
  logic                 host_to, host_from, core_to, core_from;

  assign req_fire  = htif_pcr_req_valid && htif_pcr_req_ready;
  assign host_to   = (htif_pcr_req_addr == ADDR_TO_HOST);
  assign host_from = (htif_pcr_req_addr == ADDR_FROM_HOST);
  assign core_to   = core_wen && (core_addr == ADDR_TO_HOST);
  assign core_from = core_wen && (core_addr == ADDR_FROM_HOST);

  // Host sees pre-cycle values; host read of to_host clears it unless the core writes it
  always_comb begin
    resp_load_data = '0;
    to_host_nxt    = to_host;
    from_host_nxt  = from_host;
    if (host_to) begin
      resp_load_data = to_host;
    end else if (host_from) begin
      resp_load_data = from_host;
    end
    if (req_fire && host_to) begin
      to_host_nxt = htif_pcr_req_rw ? htif_pcr_req_data : '0;
    end
    if (req_fire && host_from && htif_pcr_req_rw) begin
      from_host_nxt = htif_pcr_req_data;
    end
    if (core_to) begin
      to_host_nxt = core_wdata;
    end
    if (core_from) begin
      from_host_nxt = core_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_host        <= '0;
      from_host      <= '0;
      tohost_pending <= 1'b0;
    end else begin
      to_host        <= to_host_nxt;
      from_host      <= from_host_nxt;
      tohost_pending <= |to_host_nxt;
    end
  end

  always_comb begin
    core_rdata = '0;
    if (core_addr == ADDR_TO_HOST) begin
      core_rdata = to_host;
    end else if (core_addr == ADDR_FROM_HOST) begin
      core_rdata = from_host;
    end
  end

  vscale_htif_resp_buf #(.WIDTH(PCR_WIDTH)) u_resp_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (req_fire),
    .load_data  (resp_load_data),
    .resp_ready (htif_pcr_resp_ready),
    .resp_valid (htif_pcr_resp_valid),
    .resp_data  (htif_pcr_resp_data),
    .req_ready  (htif_pcr_req_ready)
  );

endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// Bench for the HTIF PCR responder: directed vector table, hand-written
// backpressure/reset sequences and randomized traffic against a reference model.
module tb_vscale_htif_pcr_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rw;
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data;
  logic        core_wen;
  logic [11:0] core_addr;
  logic [63:0] core_wdata, core_rdata;
  logic        tohost_pending;

  vscale_htif_pcr_responder dut (
    .clk                 (clk),
    .reset               (reset),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data),
    .core_wen            (core_wen),
    .core_addr           (core_addr),
    .core_wdata          (core_wdata),
    .core_rdata          (core_rdata),
    .tohost_pending      (tohost_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req_valid;
    logic        rw;
    logic [11:0] addr;
    logic [63:0] data;
    logic        resp_ready;
    logic        core_wen;
    logic [11:0] core_addr;
    logic [63:0] core_wdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_valid;
    logic [63:0] e_data;
    logic        e_pend;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model: host-visible registers plus the one pending response
  logic [63:0] m_to, m_from, m_resp;
  logic        m_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic v, input logic rw, input logic [11:0] a,
                               input logic [63:0] d, input logic rr, input logic cw,
                               input logic [11:0] ca, input logic [63:0] cd);
    stim_t s;
    s.req_valid = v; s.rw = rw; s.addr = a; s.data = d; s.resp_ready = rr;
    s.core_wen = cw; s.core_addr = ca; s.core_wdata = cd;
    return s;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    if (a == 12'h780) return m_to;
    if (a == 12'h781) return m_from;
    return 64'd0;
  endfunction

  task automatic model_reset();
    m_to = '0; m_from = '0; m_resp = '0; m_valid = 1'b0;
  endtask

  task automatic model_clock(input stim_t s);
    logic        accept;
    logic [63:0] nto, nfrom;
    accept = s.req_valid && (!m_valid || s.resp_ready);
    nto = m_to;
    nfrom = m_from;
    if (accept) begin
      m_resp = m_read(s.addr);
      if (s.addr == 12'h780) nto = s.rw ? s.data : 64'd0;
      if (s.addr == 12'h781 && s.rw) nfrom = s.data;
      m_valid = 1'b1;
    end else if (s.resp_ready) begin
      m_valid = 1'b0;
    end
    if (s.core_wen && s.core_addr == 12'h780) nto = s.core_wdata;
    if (s.core_wen && s.core_addr == 12'h781) nfrom = s.core_wdata;
    m_to = nto;
    m_from = nfrom;
  endtask

  // one cycle: drive at negedge, check comb outputs, clock, check registered outputs
  task automatic step(input stim_t s);
    req_valid = s.req_valid; req_rw = s.rw; req_addr = s.addr; req_data = s.data;
    resp_ready = s.resp_ready; core_wen = s.core_wen; core_addr = s.core_addr;
    core_wdata = s.core_wdata;
    #1;
    chk("req_ready", 64'(req_ready), 64'(!m_valid || s.resp_ready));
    chk("core_rdata", core_rdata, m_read(s.core_addr));
    @(posedge clk);
    model_clock(s);
    #1;
    chk("resp_valid", 64'(resp_valid), 64'(m_valid));
    chk("resp_data", resp_data, m_resp);
    chk("tohost_pending", 64'(tohost_pending), 64'(m_to != 0));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_rw = 0; req_addr = '0; req_data = '0; resp_ready = 0;
    core_wen = 0; core_addr = '0; core_wdata = '0;
  endtask

  vec_t vt[10];
  stim_t st;

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b1;
    #3;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_data", resp_data, 64'd0);
    chk("reset tohost_pending", 64'(tohost_pending), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);

    // directed table, run from the reset state
    vt[0] = '{mk(0,0,12'h000,0,1, 1,12'h780,64'h1),                  1'b0, 64'h0, 1'b1};
    vt[1] = '{mk(1,0,12'h780,0,1, 0,12'h000,0),                      1'b1, 64'h1, 1'b0};
    vt[2] = '{mk(1,1,12'h781,64'hDEAD_BEEF,1, 0,12'h781,0),          1'b1, 64'h0, 1'b0};
    vt[3] = '{mk(0,0,12'h000,0,1, 0,12'h781,0),                      1'b0, 64'h0, 1'b0};
    vt[4] = '{mk(0,0,12'h000,0,1, 1,12'h780,64'h3),                  1'b0, 64'h0, 1'b1};
    vt[5] = '{mk(1,0,12'h780,0,1, 1,12'h780,64'h7),                  1'b1, 64'h3, 1'b1};
    vt[6] = '{mk(1,0,12'h123,0,1, 0,12'h000,0),                      1'b1, 64'h0, 1'b1};
    vt[7] = '{mk(1,0,12'h781,0,1, 0,12'h000,0),                      1'b1, 64'hDEAD_BEEF, 1'b1};
    vt[8] = '{mk(1,0,12'h780,0,1, 0,12'h000,0),                      1'b1, 64'h7, 1'b0};
    vt[9] = '{mk(0,0,12'h000,0,1, 0,12'h000,0),                      1'b0, 64'h7, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(vt[i].s);
      chk($sformatf("vec%0d resp_valid", i), 64'(resp_valid), 64'(vt[i].e_valid));
      chk($sformatf("vec%0d resp_data", i), resp_data, vt[i].e_data);
      chk($sformatf("vec%0d tohost_pending", i), 64'(tohost_pending), 64'(vt[i].e_pend));
    end
    req_valid = 0; core_addr = 12'h781; #1;
    chk("from_host via core", core_rdata, 64'hDEAD_BEEF);

    // backpressure: response held, new request stalled, then back-to-back accept
    step(mk(0,0,0,0,1, 1,12'h780,64'h55));
    step(mk(1,0,12'h780,0,0, 0,0,0));
    chk("bp first resp", resp_data, 64'h55);
    for (int i = 0; i < 5; i++) begin
      step(mk(1,1,12'h781,64'hA5A5,0, 0,0,0));
      chk("bp req_ready low", 64'(req_ready), 64'd0);
      chk("bp resp_data stable", resp_data, 64'h55);
    end
    step(mk(1,1,12'h781,64'hA5A5,1, 0,0,0));
    chk("b2b resp_valid", 64'(resp_valid), 64'd1);
    chk("b2b resp_data", resp_data, 64'hDEAD_BEEF);

    // async reset with a buffered response
    step(mk(1,0,12'h781,0,0, 1,12'h780,64'h9));
    chk("pre-reset resp_valid", 64'(resp_valid), 64'd1);
    req_valid = 1; resp_ready = 1;
    #2 reset = 1'b1;
    #1;
    chk("mid reset resp_valid", 64'(resp_valid), 64'd0);
    chk("mid reset req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("reset-cycle no resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    model_reset();
    core_addr = 12'h780;
    #1;
    chk("after reset req_ready", 64'(req_ready), 64'd1);
    chk("after reset to_host", core_rdata, 64'd0);
    chk("after reset pending", 64'(tohost_pending), 64'd0);
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a, ca;
      case ($urandom_range(0, 3))
        0: a = 12'h780;
        1: a = 12'h781;
        2: a = 12'h123;
        default: a = 12'($urandom);
      endcase
      ca = ($urandom_range(0, 1) == 0) ? 12'h780 : (($urandom_range(0, 1) == 0) ? 12'h781 : 12'h7ff);
      st = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
              ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom},
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), ca,
              ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom});
      step(st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vscale_htif_pcr_responder.md
Name: vscale_htif_pcr_responder

Overview:
Target-side endpoint of the HTIF PCR request/response channel. It accepts host PCR read/write requests, owns the to_host and from_host registers, and returns one response per accepted request through a single-entry response buffer. It sits beside the CSR file inside vscale_sim_top. The core writes to_host and reads from_host over a simple side port; the host polls to_host and posts from_host.

Parameters:
PCR_WIDTH, 64, data width of requests, responses and host registers (`HTIF_PCR_WIDTH)
ADDR_WIDTH, 12, CSR address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
htif_pcr_req_valid  in  1  host request valid
htif_pcr_req_ready  out  1  responder can accept a request this cycle
htif_pcr_req_rw  in  1  1 = write, 0 = read
htif_pcr_req_addr  in  ADDR_WIDTH  CSR address
htif_pcr_req_data  in  PCR_WIDTH  write data
htif_pcr_resp_valid  out  1  response buffer holds a response
htif_pcr_resp_ready  in  1  host consumes the response
htif_pcr_resp_data  out  PCR_WIDTH  response data
core_wen  in  1  core write strobe
core_addr  in  ADDR_WIDTH  core CSR address
core_wdata  in  PCR_WIDTH  core write data
core_rdata  out  PCR_WIDTH  combinational read of the addressed register, 0 if unmapped
tohost_pending  out  1  to_host is nonzero

Behaviour:
- Reset (async, active-high): to_host=0, from_host=0, resp_valid=0, resp_data=0, tohost_pending=0. htif_pcr_req_ready=1 after reset deasserts, and is held 0 while reset is asserted.
- Handshake:
  - req_fire = req_valid & req_ready.
  - resp_fire = resp_valid & resp_ready.
  - req_ready = !resp_valid | resp_ready. This is a one-entry buffer with same-cycle pass-through of a drain.
- State machine, 2 states:
  - EMPTY: on req_fire go to FULL.
  - FULL: on resp_fire without req_fire go to EMPTY; on resp_fire with req_fire stay in FULL and load the new response; otherwise hold.
  - resp_valid = (state==FULL).
- Latency: a response is valid exactly 1 cycle after req_fire. resp_data is stable while resp_valid & !resp_ready.
- Request decoding (applied on req_fire only):
  - Read CSR_ADDR_TO_HOST (0x780): resp_data = to_host, then to_host is cleared (read-clear).
  - Read CSR_ADDR_FROM_HOST (0x781): resp_data = from_host.
  - Write FROM_HOST: from_host <= req_data; resp_data = old from_host.
  - Write TO_HOST: to_host <= req_data; resp_data = old to_host.
  - Any other address: resp_data = 0, no register change.
- Core port (applied every cycle core_wen=1):
  - Write TO_HOST: to_host <= core_wdata.
  - Write FROM_HOST: from_host <= core_wdata.
  - Other addresses are ignored.
- Simultaneous core write and host access to the same register in one cycle: the core write wins the register value. The host response returns the pre-cycle value. A host read-clear of to_host does not override a same-cycle core write.
- tohost_pending = |to_host, registered with to_host.
- A reset asserted mid-transaction drops any buffered response; no response is produced for a request accepted in the reset cycle.
- Widths: all data paths are PCR_WIDTH with no truncation. Addresses are compared over the full ADDR_WIDTH.

Decomposition:
- Shared package / existing vscale_csr_addr_map.vh: CSR_ADDR_TO_HOST, CSR_ADDR_FROM_HOST.
- vscale_ctrl_constants.vh: HTIF_PCR_WIDTH, plus new localparams for the responder states (HTIF_RESP_EMPTY, HTIF_RESP_FULL).
- One natural sub-module: vscale_htif_resp_buf, the single-entry valid/ready response buffer with drain pass-through. Register decode stays in the top module.

Test Plan:
- Core writes to_host=0x1, host reads 0x780 with resp_ready=1 -> resp_valid the next cycle, resp_data=0x1; to_host=0 afterwards; tohost_pending falls.
- Host writes 0x781 with data 0xDEAD_BEEF -> core_rdata at 0x781 = 0xDEADBEEF on the next cycle; response data = 0.
- Host holds resp_ready=0 for 5 cycles after a read -> req_ready=0 and resp_data stable throughout; raising resp_ready with req_valid=1 gives a back-to-back accept and a second response the next cycle.
- Same cycle: host reads 0x780 while the core writes to_host=0x7 (old value 0x3) -> resp_data=0x3, to_host=0x7.
- Host reads unmapped address 0x123 -> resp_data=0; to_host and from_host unchanged.
- Assert reset while resp_valid=1 -> resp_valid drops immediately (async); after release, req_ready=1 and to_host=0.
